// File: rtl/stream_sum_accumulator.sv
// Signed burst accumulator around a 32-bit carry-bypass adder with valid/ready in/out handshakes.
// Define ACC_SATURATE_EN to clamp overflowing adds to the signed extreme instead of wrapping.

module carryBypassAdder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int unsigned NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             bc;
  logic             rc;
  logic             prop;
  logic             c_msb;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Ripple inside each block; a fully propagating block forwards its carry-in directly.
  always_comb begin
    sum_o = '0;
    bc    = cin_i;
    rc    = 1'b0;
    prop  = 1'b1;
    c_msb = 1'b0;
    for (int unsigned blk = 0; blk < NBLK; blk++) begin
      rc   = bc;
      prop = 1'b1;
      for (int unsigned j = 0; j < BLOCK; j++) begin
        sum_o[blk*BLOCK+j] = p[blk*BLOCK+j] ^ rc;
        if (blk*BLOCK+j == WIDTH-1) c_msb = rc;
        rc   = g[blk*BLOCK+j] | (p[blk*BLOCK+j] & rc);
        prop = prop & p[blk*BLOCK+j];
      end
      bc = prop ? bc : rc;
    end
  end

  assign cout_o     = bc;
  assign overflow_o = c_msb ^ bc;
endmodule

module stream_sum_accumulator #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_overflow,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e             state_q;
  logic [COUNT_W-1:0] len_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_d;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [WIDTH-1:0]   add_sum;
  logic               add_ovf;
  logic               adder_cout_unused;

  carryBypassAdder #(.WIDTH(WIDTH)) u_adder (
    .a_i        (sum_q),
    .b_i        (in_data),
    .cin_i      (1'b0),
    .sum_o      (add_sum),
    .cout_o     (adder_cout_unused),
    .overflow_o (add_ovf)
  );

`ifdef ACC_SATURATE_EN
  // An overflowing add can only push toward the sign of the operand.
  assign sum_d = !add_ovf       ? add_sum :
                 in_data[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_d = add_sum;
`endif

  assign cnt_d = cnt_q + COUNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            cnt_q  <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            sum_q <= sum_d;
            ovf_q <= ovf_q | add_ovf;
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;
  assign busy         = busy_q;
endmodule
